// File: rtl/membus_fastmem16k.sv
`default_nettype none
// ============================================================================
// Module      : membus_fastmem16k
// Description : 16K x 36-bit semiconductor memory, a target on the KA10
//               memory bus. It handles read, write and read-modify-write
//               cycles, and drives the wired-OR mb bus only while it owns
//               read data.
// Revision    : 1.0  initial release
// ============================================================================
module membus_fastmem16k #(
  parameter logic [3:0] MEMSEL  = 4'b0000,
  parameter int         ACK_DLY = 2,
  parameter int         RD_DLY  = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         power,
  input  logic         membus_rq_cyc,
  input  logic         membus_rd_rq,
  input  logic         membus_wr_rq,
  input  logic [3:0]   membus_sel,
  input  logic [13:0]  membus_ma,
  input  logic         membus_fmc_select,
  input  logic [0:35]  membus_mb_in,
  input  logic         membus_wr_rs,
  output logic         membus_addr_ack,
  output logic         membus_rd_rs,
  output logic [0:35]  membus_mb_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACKW = 3'd1,
    S_RDW  = 3'd2,
    S_RDH  = 3'd3,
    S_WRW  = 3'd4,
    S_REL  = 3'd5
  } state_t;

  localparam logic [3:0] c_ACK_LOAD = 4'(ACK_DLY - 1);
  localparam logic [3:0] c_RD_LOAD  = 4'(RD_DLY - 1);

  // Storage array; deliberately untouched by reset so contents survive it.
  logic [0:35] core [0:16383];

  state_t      r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [13:0] r_ma, w_ma_nx;
  logic        r_rd, w_rd_nx;
  logic        r_wr, w_wr_nx;
  logic        r_ack, w_ack_nx;
  logic        r_rdrs, w_rdrs_nx;
  logic [0:35] r_mb, w_mb_nx;
  logic        w_we;
  logic        w_rst;
  logic        w_accept;
  logic [0:35] w_rdata;

  // Power loss behaves exactly like reset for the control path.
  assign w_rst    = reset | ~power;
  assign w_accept = membus_rq_cyc & (membus_rd_rq | membus_wr_rq) &
                    (membus_sel == MEMSEL) & ~membus_fmc_select;
  assign w_rdata  = core[r_ma];

  // Next-state and next-output logic for the bus cycle sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ma_nx    = r_ma;
    w_rd_nx    = r_rd;
    w_wr_nx    = r_wr;
    w_ack_nx   = 1'b0;
    w_rdrs_nx  = 1'b0;
    w_mb_nx    = r_mb;
    w_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mb_nx = '0;
        if (w_accept) begin
          w_ma_nx    = membus_ma;
          w_rd_nx    = membus_rd_rq;
          w_wr_nx    = membus_wr_rq;
          w_cnt_nx   = c_ACK_LOAD;
          w_state_nx = S_ACKW;
        end
      end
      S_ACKW: begin
        w_mb_nx = '0;
        if (!membus_rq_cyc) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_ack_nx = 1'b1;
          if (r_rd) begin
            w_cnt_nx   = c_RD_LOAD;
            w_state_nx = S_RDW;
          end else if (r_wr) begin
            w_state_nx = S_WRW;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_RDW: begin
        if (!membus_rq_cyc) begin
          w_mb_nx    = '0;
          w_state_nx = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_mb_nx    = w_rdata;
          w_rdrs_nx  = 1'b1;
          w_state_nx = r_wr ? S_RDH : S_REL;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_RDH: begin
        if (!membus_rq_cyc) begin
          w_mb_nx    = '0;
          w_state_nx = S_IDLE;
        end else if (membus_wr_rs) begin
          w_we       = 1'b1;
          w_mb_nx    = '0;
          w_state_nx = S_REL;
        end
      end
      S_WRW: begin
        w_mb_nx = '0;
        if (!membus_rq_cyc) begin
          w_state_nx = S_IDLE;
        end else if (membus_wr_rs) begin
          w_we       = 1'b1;
          w_state_nx = S_REL;
        end
      end
      S_REL: begin
        // Read-only cycles keep their data on the bus until the processor
        // releases the cycle; other cycles already arrive here with zero.
        if (!membus_rq_cyc) begin
          w_mb_nx    = '0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_mb_nx    = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ma    <= 14'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ack   <= 1'b0;
      r_rdrs  <= 1'b0;
      r_mb    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ma    <= w_ma_nx;
      r_rd    <= w_rd_nx;
      r_wr    <= w_wr_nx;
      r_ack   <= w_ack_nx;
      r_rdrs  <= w_rdrs_nx;
      r_mb    <= w_mb_nx;
    end
  end

  // Write port: data is captured from mb_in on the same edge as wr_rs.
  always_ff @(posedge clk) begin
    if (w_we && !w_rst) begin
      core[r_ma] <= membus_mb_in;
    end
  end

  assign membus_addr_ack = r_ack;
  assign membus_rd_rs    = r_rdrs;
  assign membus_mb_out   = r_mb;

endmodule
`default_nettype wire
